shift_sequencer: RTL

Multi-position shift sequencer for the integer ALU datapath. Accepts an operand, shift direction, mode and amount through a valid/ready handshake. Performs the shift as a sequence of single-bit shifts, one per clock. Presents the result, last shifted-out bit and a zero flag through a second valid/ready handshake. Sits directly upstream of the ALU result path and extends the single-bit shift stage to arbitrary amounts.

---
 rtl/shift_sequencer.sv | 125 ++++++++++++
 1 files changed

// File: rtl/shift_sequencer.sv
// rtl/shift_sequencer.sv - multi-position shift sequencer, one single-bit shift per clock
// Extends the ALU single-bit shift stage to arbitrary amounts behind valid/ready handshakes.
module shift_sequencer #(
   parameter int WIDTH = 4,
   parameter int AMT_W = 3
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic [AMT_W-1:0] in_amount,
   input  logic             in_right,
   input  logic             in_arith,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_carry,
   output logic             out_zero,
   output logic             busy
);

   localparam int CNT_W = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   work_q, work_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic               right_q, right_d;
   logic               arith_q, arith_d;
   logic [WIDTH-1:0]   out_data_q, out_data_d;
   logic               out_carry_q, out_carry_d;
   logic               out_zero_q, out_zero_d;

   logic [CNT_W-1:0]   k_eff;
   logic [WIDTH-1:0]   step_data;
   logic               step_carry;

   // Amounts beyond WIDTH behave exactly like a WIDTH-position shift.
   always_comb begin
      k_eff = (32'(in_amount) > 32'(WIDTH)) ? CNT_W'(WIDTH) : CNT_W'(in_amount);
      if (right_q) begin
         step_data  = {arith_q & work_q[WIDTH-1], work_q[WIDTH-1:1]};
         step_carry = work_q[0];
      end else begin
         step_data  = {work_q[WIDTH-2:0], 1'b0};
         step_carry = work_q[WIDTH-1];
      end
   end

   always_comb begin
      state_d     = state_q;
      work_d      = work_q;
      count_d     = count_q;
      right_d     = right_q;
      arith_d     = arith_q;
      out_data_d  = out_data_q;
      out_carry_d = out_carry_q;
      out_zero_d  = out_zero_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               work_d  = in_data;
               right_d = in_right;
               arith_d = in_arith;
               count_d = k_eff;
               if (k_eff == '0) begin
                  state_d     = DONE;
                  out_data_d  = in_data;
                  out_carry_d = 1'b0;
                  out_zero_d  = (in_data == '0);
               end else begin
                  state_d = SHIFT;
               end
            end
         end
         SHIFT: begin
            work_d  = step_data;
            count_d = count_q - CNT_W'(1);
            // The final step publishes the result on the same edge it moves to DONE.
            if (count_q == CNT_W'(1)) begin
               state_d     = DONE;
               out_data_d  = step_data;
               out_carry_d = step_carry;
               out_zero_d  = (step_data == '0);
            end
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         work_q      <= '0;
         count_q     <= '0;
         right_q     <= 1'b0;
         arith_q     <= 1'b0;
         out_data_q  <= '0;
         out_carry_q <= 1'b0;
         out_zero_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         work_q      <= work_d;
         count_q     <= count_d;
         right_q     <= right_d;
         arith_q     <= arith_d;
         out_data_q  <= out_data_d;
         out_carry_q <= out_carry_d;
         out_zero_q  <= out_zero_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign busy      = (state_q != IDLE);
   assign out_data  = out_data_q;
   assign out_carry = out_carry_q;
   assign out_zero  = out_zero_q;

endmodule
